// File: rtl/master_port.sv
// master_port: parallel local request -> bit-serial bus master (address then data, MSB first),
// with serial read-data deserializer. Define MASTER_PORT_TIMEOUT_EN to add a watchdog abort.
module master_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  input  logic                  rd_bus,
  input  logic                  slave_valid,
  output logic                  master_ready
);
  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] F_LAST = CW'(SW - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TRAIL, RX, DONE} state_t;

  state_t                state;
  logic [SW-1:0]         sr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_nxt;
  logic                  tx_beat;
  logic                  rx_beat;

  // Bus-side outputs decode registered state only; no input reaches them combinationally.
  assign req_ready    = rstn && (state == IDLE);
  assign master_valid = (state == ADDR) || (state == DATA) || (state == TRAIL);
  assign wr_bus       = ((state == ADDR) || (state == DATA)) && sr[SW-1];
  assign master_ready = (state == RX);
  assign rsp_valid    = (state == DONE);
  assign tx_beat      = master_valid && slave_ready;
  assign rx_beat      = slave_valid && master_ready;
  assign rx_nxt       = {rx_sh[DATA_WIDTH-2:0], rd_bus};

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
  logic          err_q;
  logic          wd_clr;

  // Every state exit from a watched state is either a beat or the trail end-of-frame.
  assign wd_clr  = tx_beat || rx_beat || ((state == TRAIL) && !slave_ready);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      rx_sh     <= '0;
      rsp_rdata <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
      wd        <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          sr    <= {req_addr, req_wdata};
          mode  <= req_write;
          cnt   <= '0;
          state <= ADDR;
        end
        // cnt runs across address and data so one compare per phase ends it.
        ADDR, DATA: if (tx_beat) begin
          sr  <= sr << 1;
          cnt <= cnt + 1'b1;
          if (state == ADDR && cnt == A_LAST) state <= mode ? DATA : TRAIL;
          if (state == DATA && cnt == F_LAST) state <= TRAIL;
        end
        TRAIL: if (!slave_ready) begin
          cnt   <= '0;
          state <= mode ? DONE : RX;
          if (mode) rsp_rdata <= '0;
        end
        RX: if (rx_beat) begin
          rx_sh <= rx_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == D_LAST) begin
            rsp_rdata <= rx_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          mode  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef MASTER_PORT_TIMEOUT_EN
      if (state == ADDR || state == DATA || state == TRAIL || state == RX) begin
        if (wd_clr) wd <= '0;
        else if (wd == WD_LAST) begin
          wd        <= '0;
          cnt       <= '0;
          state     <= DONE;
          err_q     <= 1'b1;
          rsp_rdata <= '0;
        end else wd <= wd + 1'b1;
      end else begin
        wd    <= '0;
        err_q <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port with a cycle-stepped serial slave model (RAM, entry cycle, pad beat).
module tb_master_port;
  localparam int AW = 16;
  localparam int DW = 8;
`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready;
  logic [DW-1:0] rsp_rdata;
  logic          slave_ready = 1'b0, rd_bus = 1'b0, slave_valid = 1'b0;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mode(mode),
    .wr_bus(wr_bus), .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid), .master_ready(master_ready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  req_t req_q[$];
  logic [7:0] ram [0:255];

  // slave model state
  bit            s_active = 0, s_mute = 0;
  int            s_cnt = 0, s_len = 0, s_pad = 0, s_tx_left = 0, s_beats = 0;
  int            s_stall_at = 0, s_stall_left = 0;
  logic [2:0]    s_stall_bits = '0;
  logic [AW+DW-1:0] s_frame = '0, last_frame = '0;
  logic [DW-1:0] s_word = '0;

  // observation state
  int            cyc = 0, n_rsp = 0, rsp_cyc = 0, acc_cyc = 0, rx_cyc = 0, mode_bad = 0, pad_bad = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0, exp_mode = 1'b0, mr_prev = 1'b0;

  // One bus cycle: observe outputs at negedge, then drive request and slave inputs for the next edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rsp_valid) begin n_rsp++; rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err; end
    if ((master_valid || master_ready || rsp_valid) && mode !== exp_mode) mode_bad++;
    if (master_ready && !mr_prev) rx_cyc = cyc;
    mr_prev = master_ready;
    if (req_q.size() > 0) begin
      req_valid = 1'b1; req_write = req_q[0].write; req_addr = req_q[0].addr; req_wdata = req_q[0].wdata;
      if (req_ready) begin exp_mode = req_q[0].write; acc_cyc = cyc; void'(req_q.pop_front()); end
    end else req_valid = 1'b0;
    slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;
    if (master_valid) begin
      if (!s_active) begin
        s_active = 1; s_cnt = 0; s_pad = 1; s_frame = '0; s_len = mode ? AW + DW : AW;
      end else if (s_cnt == s_stall_at && s_stall_left > 0) begin
        s_stall_left--; s_stall_bits = {s_stall_bits[1:0], wr_bus};
      end else if (s_cnt < s_len) begin
        slave_ready = 1'b1; s_frame = {s_frame[AW+DW-2:0], wr_bus}; s_cnt++;
      end else if (s_pad > 0) begin
        slave_ready = 1'b1; s_pad--; if (wr_bus !== 1'b0) pad_bad++;
      end else begin
        s_active = 0; s_beats = s_cnt; last_frame = s_frame;
        if (s_len == AW + DW) ram[s_frame[DW+7:DW]] = s_frame[DW-1:0];
        else begin s_word = ram[s_frame[7:0]]; s_tx_left = s_mute ? 0 : DW; end
      end
    end else if (master_ready && s_tx_left > 0) begin
      slave_valid = 1'b1; rd_bus = s_word[s_tx_left-1]; s_tx_left--;
    end
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    int n0;
    n0 = n_rsp; got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (n_rsp != n0) got = 1;
    end
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    s_active = 0; s_tx_left = 0; s_stall_left = 0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if ({rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready} !== 6'b0)
      begin errors++; $display("FAIL reset_outputs got=%b want=000000", {rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready}); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h want=00", rsp_rdata); end
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write();
    bit got; int n0;
    mode_bad = 0; pad_bad = 0; n0 = n_rsp;
    req_q.push_back('{1'b1, 16'h0025, 8'hA5});
    wait_rsp(60, got);
    checks++; if (!got) begin errors++; $display("FAIL wr_rsp got=none want=rsp_valid"); end
    checks++; if (last_err !== 1'b0 || last_rdata !== 8'h00)
      begin errors++; $display("FAIL wr_rsp_fields got=err%b/%h want=err0/00", last_err, last_rdata); end
    checks++; if (last_frame !== 24'h0025A5 || s_beats != 24)
      begin errors++; $display("FAIL wr_frame got=%h/%0d want=0025a5/24", last_frame, s_beats); end
    checks++; if (ram[8'h25] !== 8'hA5) begin errors++; $display("FAIL wr_ram got=%h want=a5", ram[8'h25]); end
    checks++; if (mode_bad != 0 || pad_bad != 0) begin errors++; $display("FAIL wr_mode_pad got=%0d/%0d want=0/0", mode_bad, pad_bad); end
    checks++; if (rsp_cyc - acc_cyc != 28) begin errors++; $display("FAIL wr_latency got=%0d want=28", rsp_cyc - acc_cyc); end
    step(); step();
    checks++; if (n_rsp != n0 + 1) begin errors++; $display("FAIL wr_single_pulse got=%0d want=1", n_rsp - n0); end
  endtask

  task automatic test_read();
    bit got;
    mode_bad = 0;
    req_q.push_back('{1'b0, 16'h0025, 8'h00});
    wait_rsp(60, got);
    checks++; if (!got || last_rdata !== 8'hA5 || last_err !== 1'b0)
      begin errors++; $display("FAIL rd_data got=%0d/%h/%b want=1/a5/0", got, last_rdata, last_err); end
    checks++; if (last_frame !== 24'h000025 || s_beats != 16)
      begin errors++; $display("FAIL rd_frame got=%h/%0d want=000025/16", last_frame, s_beats); end
    checks++; if (mode_bad != 0) begin errors++; $display("FAIL rd_mode got=%0d want=0", mode_bad); end
    checks++; if (rsp_cyc - rx_cyc != 8 || rsp_cyc - acc_cyc != 28)
      begin errors++; $display("FAIL rd_timing got=%0d/%0d want=8/28", rsp_cyc - rx_cyc, rsp_cyc - acc_cyc); end
  endtask

  task automatic test_stall();
    bit got;
    s_stall_at = 8; s_stall_left = 3; s_stall_bits = '0;
    req_q.push_back('{1'b1, 16'h0081, 8'h5A});
    wait_rsp(70, got);
    checks++; if (!got || s_stall_left != 0 || s_stall_bits !== 3'b111)
      begin errors++; $display("FAIL stall_hold got=%0d/%0d/%b want=1/0/111", got, s_stall_left, s_stall_bits); end
    checks++; if (last_frame !== 24'h00815A || s_beats != 24)
      begin errors++; $display("FAIL stall_frame got=%h/%0d want=00815a/24", last_frame, s_beats); end
    checks++; if (ram[8'h81] !== 8'h5A) begin errors++; $display("FAIL stall_ram got=%h want=5a", ram[8'h81]); end
    checks++; if (rsp_cyc - acc_cyc != 31) begin errors++; $display("FAIL stall_latency got=%0d want=31", rsp_cyc - acc_cyc); end
  endtask

  task automatic test_reset_mid();
    bit hit, got; int n0;
    hit = 0;
    req_q.push_back('{1'b1, 16'h0040, 8'hC3});
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (s_active && s_cnt == AW + 4) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach got=0 want=1"); end
    rstn = 1'b0; n0 = n_rsp;
    step();
    checks++; if (master_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL rmid_in_reset got=%b%b%b want=000", master_valid, rsp_valid, req_ready); end
    rstn = 1'b1;
    s_active = 0; s_tx_left = 0;
    #1;
    checks++; if ({req_ready, master_valid, master_ready, mode, wr_bus} !== 5'b10000)
      begin errors++; $display("FAIL rmid_idle got=%b want=10000", {req_ready, master_valid, master_ready, mode, wr_bus}); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (n_rsp != n0 || ram[8'h40] !== 8'h00)
      begin errors++; $display("FAIL rmid_no_rsp got=%0d/%h want=0/00", n_rsp - n0, ram[8'h40]); end
    req_q.push_back('{1'b0, 16'h0025, 8'h00});
    wait_rsp(60, got);
    checks++; if (!got || last_rdata !== 8'hA5) begin errors++; $display("FAIL rmid_read got=%0d/%h want=1/a5", got, last_rdata); end
  endtask

  task automatic test_timeout();
    bit got; int n0;
    s_mute = 1; n0 = n_rsp;
    req_q.push_back('{1'b0, 16'h0025, 8'h00});
`ifdef MASTER_PORT_TIMEOUT_EN
    wait_rsp(80, got);
    checks++; if (!got || last_err !== 1'b1 || last_rdata !== 8'h00)
      begin errors++; $display("FAIL tmo_rsp got=%0d/%b/%h want=1/1/00", got, last_err, last_rdata); end
    checks++; if (rsp_cyc - rx_cyc != 8) begin errors++; $display("FAIL tmo_delay got=%0d want=8", rsp_cyc - rx_cyc); end
`else
    got = 0;
    for (int i = 0; i < 60; i++) step();
    checks++; if (n_rsp != n0) begin errors++; $display("FAIL tmo_wait got=%0d want=0", n_rsp - n0); end
    checks++; if (master_ready !== 1'b1) begin errors++; $display("FAIL tmo_in_rx got=%b want=1", master_ready); end
`endif
    pulse_reset();
    s_mute = 0;
  endtask

  task automatic test_back_to_back();
    bit got; int r1;
    req_q.push_back('{1'b1, 16'h0003, 8'h11});
    req_q.push_back('{1'b0, 16'h0003, 8'h00});
    wait_rsp(60, got);
    r1 = rsp_cyc;
    checks++; if (!got || ram[8'h03] !== 8'h11) begin errors++; $display("FAIL b2b_write got=%0d/%h want=1/11", got, ram[8'h03]); end
    wait_rsp(60, got);
    checks++; if (acc_cyc != r1 + 1) begin errors++; $display("FAIL b2b_accept got=%0d want=%0d", acc_cyc, r1 + 1); end
    checks++; if (!got || last_rdata !== 8'h11 || last_err !== 1'b0)
      begin errors++; $display("FAIL b2b_read got=%0d/%h/%b want=1/11/0", got, last_rdata, last_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
